// File: rtl/quantum_scheduler.sv
// Preemptive round-robin scheduler: counts user-mode retires against a per-slot quantum,
// handles I/O yield and termination, and holds a switch request until acknowledged.
module quantum_scheduler #(
  parameter int PC_WIDTH        = 32,
  parameter int NUM_PROC        = 4,
  parameter int PID_WIDTH       = 2,
  parameter int QUANTUM_WIDTH   = 8,
  parameter int DEFAULT_QUANTUM = 5,
  parameter int OS_LIMIT        = 300
) (
  input  logic                     i_clk,
  input  logic                     i_rst_n,
  input  logic                     i_instr_valid,
  input  logic [PC_WIDTH-1:0]      i_pc,
  input  logic                     i_io_request,
  input  logic                     i_proc_end,
  input  logic [NUM_PROC-1:0]      i_io_done,
  input  logic                     i_cfg_we,
  input  logic                     i_cfg_start,
  input  logic [PID_WIDTH-1:0]     i_cfg_pid,
  input  logic [QUANTUM_WIDTH-1:0] i_cfg_quantum,
  input  logic [PC_WIDTH-1:0]      i_cfg_pc,
  input  logic                     i_switch_ack,
  output logic                     o_switch_req,
  output logic [PID_WIDTH-1:0]     o_cur_pid,
  output logic [PID_WIDTH-1:0]     o_next_pid,
  output logic [PC_WIDTH-1:0]      o_saved_pc,
  output logic [PC_WIDTH-1:0]      o_resume_pc,
  output logic                     o_idle
);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_RUN    = 2'd1,
    ST_SWITCH = 2'd2
  } state_t;

  localparam logic [PC_WIDTH-1:0]    LP_OS_LIMIT = PC_WIDTH'(OS_LIMIT);
  localparam logic [QUANTUM_WIDTH:0] LP_ONE_Q    = (QUANTUM_WIDTH+1)'(1);

  state_t                   r_state;
  logic [NUM_PROC-1:0]      r_ready;
  logic [NUM_PROC-1:0]      r_blocked;
  logic [QUANTUM_WIDTH-1:0] r_quantum [NUM_PROC];
  logic [PC_WIDTH-1:0]      r_spc     [NUM_PROC];
  logic [QUANTUM_WIDTH-1:0] r_count;
  logic [PID_WIDTH-1:0]     r_cur_pid;
  logic [PID_WIDTH-1:0]     r_next_pid;
  logic [PC_WIDTH-1:0]      r_saved_pc;
  logic [PC_WIDTH-1:0]      r_resume_pc;
  logic                     r_switch_req;
  logic                     r_idle;

  logic                     w_run_act;
  logic                     w_counted;
  logic                     w_ev_end;
  logic                     w_ev_io;
  logic                     w_ev_exp;
  logic                     w_switch_ev;
  logic [QUANTUM_WIDTH:0]   w_cnt_inc;
  logic [PC_WIDTH-1:0]      w_pc_inc;
  logic [NUM_PROC-1:0]      w_ready_nxt;
  logic [NUM_PROC-1:0]      w_blocked_nxt;
  logic [PC_WIDTH-1:0]      w_spc_nxt [NUM_PROC];
  logic [NUM_PROC-1:0]      w_cand;
  logic                     w_sel_found;
  logic [PID_WIDTH-1:0]     w_sel_pid;

  // A programmed quantum of zero behaves as a quantum of one.
  function automatic logic [QUANTUM_WIDTH:0] eff_quantum(input logic [QUANTUM_WIDTH-1:0] q);
    if (q == {QUANTUM_WIDTH{1'b0}}) eff_quantum = LP_ONE_Q;
    else                            eff_quantum = {1'b0, q};
  endfunction

  assign w_run_act   = (r_state == ST_RUN) && i_instr_valid;
  assign w_counted   = w_run_act && (i_pc > LP_OS_LIMIT);
  assign w_cnt_inc   = {1'b0, r_count} + LP_ONE_Q;
  assign w_pc_inc    = i_pc + PC_WIDTH'(1);
  assign w_ev_end    = w_run_act && i_proc_end;
  assign w_ev_io     = w_run_act && !i_proc_end && i_io_request;
  assign w_ev_exp    = w_counted && !i_proc_end && !i_io_request &&
                       (w_cnt_inc >= eff_quantum(r_quantum[r_cur_pid]));
  assign w_switch_ev = w_ev_end || w_ev_io || w_ev_exp;

  // Next per-slot state: run event first, then unblock, then cfg_start (set wins).
  always_comb begin
    w_ready_nxt   = r_ready;
    w_blocked_nxt = r_blocked;
    w_spc_nxt     = r_spc;
    if (w_ev_end) begin
      w_ready_nxt[r_cur_pid] = 1'b0;
    end else if (w_ev_io) begin
      w_blocked_nxt[r_cur_pid] = 1'b1;
      w_spc_nxt[r_cur_pid]     = w_pc_inc;
    end else if (w_ev_exp) begin
      w_spc_nxt[r_cur_pid] = w_pc_inc;
    end else begin
      w_ready_nxt[r_cur_pid] = r_ready[r_cur_pid];
    end
    w_blocked_nxt = w_blocked_nxt & ~i_io_done;
    if (i_cfg_start) begin
      w_ready_nxt[i_cfg_pid]   = 1'b1;
      w_blocked_nxt[i_cfg_pid] = 1'b0;
      w_spc_nxt[i_cfg_pid]     = i_cfg_pc;
    end else begin
      w_ready_nxt[i_cfg_pid] = w_ready_nxt[i_cfg_pid];
    end
  end

  // IDLE wakes on already-registered readiness; RUN selects on the post-event view.
  assign w_cand = (r_state == ST_IDLE) ? (r_ready & ~r_blocked) : (w_ready_nxt & ~w_blocked_nxt);

  // Round-robin pick from cur_pid+1; descending scan so the nearest slot wins, cur_pid last.
  always_comb begin
    int v_idx;
    v_idx       = 0;
    w_sel_found = 1'b0;
    w_sel_pid   = r_cur_pid;
    for (int k = NUM_PROC; k >= 1; k--) begin
      v_idx = int'(r_cur_pid) + k;
      if (v_idx >= NUM_PROC) v_idx = v_idx - NUM_PROC;
      else                   v_idx = v_idx;
      if (w_cand[PID_WIDTH'(v_idx)]) begin
        w_sel_found = 1'b1;
        w_sel_pid   = PID_WIDTH'(v_idx);
      end else begin
        w_sel_found = w_sel_found;
      end
    end
  end

  // Scheduler FSM, per-slot tables and registered outputs.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state      <= ST_IDLE;
      r_ready      <= {NUM_PROC{1'b0}};
      r_blocked    <= {NUM_PROC{1'b0}};
      r_count      <= {QUANTUM_WIDTH{1'b0}};
      r_cur_pid    <= {PID_WIDTH{1'b0}};
      r_next_pid   <= {PID_WIDTH{1'b0}};
      r_saved_pc   <= {PC_WIDTH{1'b0}};
      r_resume_pc  <= {PC_WIDTH{1'b0}};
      r_switch_req <= 1'b0;
      r_idle       <= 1'b1;
      for (int i = 0; i < NUM_PROC; i++) begin
        r_quantum[i] <= QUANTUM_WIDTH'(DEFAULT_QUANTUM);
        r_spc[i]     <= {PC_WIDTH{1'b0}};
      end
    end else begin
      r_ready   <= w_ready_nxt;
      r_blocked <= w_blocked_nxt;
      r_spc     <= w_spc_nxt;
      if (i_cfg_we) r_quantum[i_cfg_pid] <= i_cfg_quantum;
      else          r_quantum[i_cfg_pid] <= r_quantum[i_cfg_pid];
      case (r_state)
        ST_IDLE: begin
          if (w_sel_found) begin
            r_state      <= ST_SWITCH;
            r_switch_req <= 1'b1;
            r_idle       <= 1'b0;
            r_next_pid   <= w_sel_pid;
            r_saved_pc   <= r_spc[r_cur_pid];
            r_resume_pc  <= w_spc_nxt[w_sel_pid];
          end else begin
            r_idle <= 1'b1;
          end
        end
        ST_RUN: begin
          if (w_switch_ev) begin
            r_saved_pc <= w_ev_end ? r_spc[r_cur_pid] : w_pc_inc;
            if (w_sel_found) begin
              r_state      <= ST_SWITCH;
              r_switch_req <= 1'b1;
              r_next_pid   <= w_sel_pid;
              r_resume_pc  <= w_spc_nxt[w_sel_pid];
            end else begin
              r_state      <= ST_IDLE;
              r_switch_req <= 1'b0;
              r_idle       <= 1'b1;
            end
          end else if (w_counted) begin
            r_count <= w_cnt_inc[QUANTUM_WIDTH-1:0];
          end else begin
            r_count <= r_count;
          end
        end
        ST_SWITCH: begin
          if (i_switch_ack) begin
            r_state      <= ST_RUN;
            r_cur_pid    <= r_next_pid;
            r_count      <= {QUANTUM_WIDTH{1'b0}};
            r_switch_req <= 1'b0;
          end else begin
            r_switch_req <= 1'b1;
          end
        end
        default: begin
          r_state      <= ST_IDLE;
          r_switch_req <= 1'b0;
          r_idle       <= 1'b1;
        end
      endcase
    end
  end

  assign o_switch_req = r_switch_req;
  assign o_cur_pid    = r_cur_pid;
  assign o_next_pid   = r_next_pid;
  assign o_saved_pc   = r_saved_pc;
  assign o_resume_pc  = r_resume_pc;
  assign o_idle       = r_idle;

endmodule
